// File: rtl/mem_responder.sv
// mem_responder: 64 x 8-bit memory responder with a single-request handshake.
// Writes complete in IDLE with a one-cycle wack pulse. Reads pass through
// RD_ADDR (fetch) and RD_DATA (rvalid pulse), giving a fixed two-cycle latency.
// Optional build macro MEM_RESPONDER_STATS_EN adds saturating 16-bit
// wr_count / rd_count outputs.

module mem_responder #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       wack,
  output logic [7:0] rdata,
  output logic       rvalid
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic [5:0] addr_q;
  logic [7:0] data_q;
  logic       wack_q;
  logic [7:0] mem [DEPTH];

  logic in_idle;
  logic accept_wr;
  logic accept_rd;

  assign in_idle   = (state_q == IDLE);
  assign accept_wr = in_idle && en && wr;
  assign accept_rd = in_idle && en && !wr;

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept_rd ? RD_ADDR : IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured read address, fetched byte and write acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wack_q  <= accept_wr;
      if (accept_rd) begin
        addr_q <= addr;
      end
      if (state_q == RD_ADDR) begin
        data_q <= mem[addr_q];
      end
    end
  end

  // Storage array; cleared asynchronously so reset never waits for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (accept_wr) begin
      mem[addr] <= wdata;
    end
  end

  // Outputs decode straight from state so reset forces idle values immediately.
  always_comb begin
    ready  = in_idle;
    wack   = wack_q;
    rvalid = (state_q == RD_DATA);
    rdata  = rvalid ? data_q : 8'h00;
  end

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] wr_count_q;
  logic [15:0] rd_count_q;

  // Saturating transaction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (accept_wr && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if ((state_q == RD_DATA) && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against an array model of the memory and a fixed timeline
// for each transaction (wack one cycle after a write accept, rvalid two cycles
// after a read accept).

`timescale 1ns / 1ps

module tb_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       wack;
  logic [7:0] rdata;
  logic       rvalid;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  int          exp_wr_count;
  int          exp_rd_count;
`endif

  int checks;
  int errors;

  logic [7:0] model_mem [64];

  mem_responder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .wack   (wack),
    .rdata  (rdata),
    .rvalid (rvalid)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .wr_count (wr_count),
    .rd_count (rd_count)
`endif
  );

  // 25 MHz clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
`ifdef MEM_RESPONDER_STATS_EN
    exp_wr_count = 0;
    exp_rd_count = 0;
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ready !== 1'b1 || wack !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL %s: ready=%b wack=%b rvalid=%b rdata=%h, required 1 0 0 00",
               name, ready, wack, rvalid, rdata);
    end
  endtask

  // Accepts a write at the next edge and checks the wack that follows it.
  // en is left asserted so callers can issue back-to-back writes.
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    en = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    model_mem[a] = d;
`ifdef MEM_RESPONDER_STATS_EN
    if (exp_wr_count < 65535) exp_wr_count++;
`endif
    checks++;
    if (wack !== 1'b1 || ready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_ack a=%0d: wack=%b ready=%b rvalid=%b, required 1 1 0",
               a, wack, ready, rvalid);
    end
  endtask

  // Accepts a read and checks the full two-cycle timeline.
  task automatic do_read(input logic [5:0] a);
    logic [7:0] exp;
    en = 1'b1; wr = 1'b0; addr = a; wdata = $urandom;
    tick();
    exp = model_mem[a];
    en = 1'b0;
    wr = $urandom; addr = $urandom; wdata = $urandom;
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || wack !== 1'b0) begin
      errors++;
      $display("FAIL read_c1 a=%0d: ready=%b rvalid=%b wack=%b, required 0 0 0",
               a, ready, rvalid, wack);
    end
    tick();
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b1 || rdata !== exp) begin
      errors++;
      $display("FAIL read_c2 a=%0d: ready=%b rvalid=%b rdata=%h, required 0 1 %h",
               a, ready, rvalid, rdata, exp);
    end
`ifdef MEM_RESPONDER_STATS_EN
    if (exp_rd_count < 65535) exp_rd_count++;
`endif
    tick();
    check_idle_outputs("read_c3");
  endtask

  task automatic test_reset();
    en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #2;
    check_idle_outputs("reset_async");
    tick();
    tick();
    check_idle_outputs("reset_held");
    model_clear();
    #10;
    rst_n = 1'b1;
    tick();
    check_idle_outputs("reset_released");
`ifdef MEM_RESPONDER_STATS_EN
    checks++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: wr_count=%0d rd_count=%0d, required 0 0",
               wr_count, rd_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_write(6'd12, 8'hA5);
    do_write(6'd14, 8'h3C);
    en = 1'b0;
    tick();
    check_idle_outputs("b2b_after");
    do_read(6'd12);
    do_read(6'd14);
  endtask

  task automatic test_ignore_while_busy();
    en = 1'b1; wr = 1'b0; addr = 6'd23;
    tick();
    // Hold a write request through RD_ADDR and RD_DATA; it must be dropped.
    en = 1'b1; wr = 1'b1; addr = 6'd48; wdata = 8'h77;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== model_mem[23] || wack !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_read: rvalid=%b rdata=%h wack=%b ready=%b, required 1 %h 0 0",
               rvalid, rdata, wack, ready, model_mem[23]);
    end
`ifdef MEM_RESPONDER_STATS_EN
    exp_rd_count++;
`endif
    tick();
    en = 1'b0;
    check_idle_outputs("busy_ignored_wr");
    tick();
    check_idle_outputs("busy_no_late_wack");
    do_read(6'd48);
  endtask

  task automatic test_idle_hold();
    en = 1'b0; wr = 1'b1; addr = 6'd56; wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle_outputs("idle_hold");
    end
    do_read(6'd56);
  endtask

  task automatic test_boundary();
    do_write(6'd63, 8'hFF);
    do_read(6'd63);
    do_read(6'd0);
  endtask

  task automatic test_random();
    int kind;
    logic [5:0] a;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      if (kind < 2) begin
        en = 1'b0; wr = $urandom; addr = $urandom; wdata = $urandom;
        tick();
        check_idle_outputs("rand_idle");
      end else if (kind < 6) begin
        do_write(a, 8'($urandom));
      end else if (kind < 8) begin
        // Read straight after a write to the same address.
        do_write(a, 8'($urandom));
        do_read(a);
      end else begin
        do_read(a);
      end
    end
    en = 1'b0;
    tick();
`ifdef MEM_RESPONDER_STATS_EN
    checks++;
    if (wr_count !== 16'(exp_wr_count) || rd_count !== 16'(exp_rd_count)) begin
      errors++;
      $display("FAIL rand_counts: wr_count=%0d rd_count=%0d, required %0d %0d",
               wr_count, rd_count, exp_wr_count, exp_rd_count);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    do_write(6'd12, 8'hA5);
    en = 1'b1; wr = 1'b0; addr = 6'd12;
    tick();
    en = 1'b0;
    rst_n = 1'b0;
    #5;
    check_idle_outputs("midread_in_reset");
    model_clear();
    #5;
    rst_n = 1'b1;
    tick();
    check_idle_outputs("midread_no_rvalid");
    tick();
    check_idle_outputs("midread_settled");
`ifdef MEM_RESPONDER_STATS_EN
    checks++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midread_counts: wr_count=%0d rd_count=%0d, required 0 0",
               wr_count, rd_count);
    end
`endif
    do_read(6'd12);
    do_read(6'd63);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_ignore_while_busy();
    test_idle_hold();
    test_boundary();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
